// File: rtl/spectrum_peak_finder.sv
// -----------------------------------------------------------------------------
// spectrum_peak_finder
//
// Scans one frame of FFT squared-magnitude samples and reports the largest bin
// in the lower (non-mirrored) part of the spectrum. The result is presented as
// a one-cycle data_valid pulse with data/addr held until the next result. This
// block feeds the UART result packer, which latches data/addr on data_valid.
//
// Compile-time option:
//   PEAK_DC_SKIP_EN - when defined, bins 0..DC_BINS-1 are never candidates.
//                     This keeps ADC offset leakage from winning the search.
//                     When undefined, the candidate region starts at bin 0.
//
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset
//   s_valid     input sample strobe (no backpressure, one sample per cycle)
//   s_data      unsigned squared magnitude, DATA_W bits
//   s_last      final sample of the frame, qualified by s_valid
//   data_valid  one-cycle pulse, a new result is on data/addr
//   data        peak magnitude, held until the next result
//   addr        peak bin index, held until the next result
//   frame_err   one-cycle pulse, a malformed frame was discarded
// -----------------------------------------------------------------------------
module spectrum_peak_finder #(
    parameter int DATA_W     = 25,
    parameter int ADDR_W     = 11,
    parameter int FRAME_LEN  = 4096,
    parameter int SEARCH_LEN = 2048,
    parameter int DC_BINS    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              data_valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr,
    output logic              frame_err
);

    localparam int IDX_W = $clog2(FRAME_LEN);

    // Limits are one bit wider than idx so SEARCH_LEN == FRAME_LEN still fits.
    localparam logic [IDX_W:0]   SEARCH_LIM = (IDX_W + 1)'(SEARCH_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_LEN - 1);

    // Reject configurations where the search region is empty or its indices
    // cannot be represented on addr.
    if ((SEARCH_LEN <= DC_BINS) || (SEARCH_LEN > (1 << ADDR_W))) begin : gBadConfig
        $error("spectrum_peak_finder: SEARCH_LEN must be > DC_BINS and <= 2**ADDR_W");
    end

    logic [IDX_W-1:0]  idx_q,        idx_d;
    logic [DATA_W-1:0] max_val_q,    max_val_d;
    logic [IDX_W-1:0]  max_idx_q,    max_idx_d;
    logic              have_cand_q,  have_cand_d;
    logic              data_valid_q, data_valid_d;
    logic              frame_err_q,  frame_err_d;
    logic [DATA_W-1:0] data_q,       data_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;

    logic              belowSearch;
    logic              aboveDc;
    logic              inRegion;
    logic              takeSample;
    logic              atLast;
    logic [DATA_W-1:0] candVal;
    logic [IDX_W-1:0]  candIdx;
    logic [ADDR_W-1:0] candAddr;

    assign belowSearch = ({1'b0, idx_q} < SEARCH_LIM);

`ifdef PEAK_DC_SKIP_EN
    localparam logic [IDX_W:0] DC_LIM = (IDX_W + 1)'(DC_BINS);
    assign aboveDc = ({1'b0, idx_q} >= DC_LIM);
`else
    assign aboveDc = 1'b1;
`endif

    assign inRegion = belowSearch && aboveDc;

    // The first candidate of a frame loads unconditionally; after that only a
    // strictly larger sample replaces the stored peak, so ties keep the lowest bin.
    assign takeSample = inRegion && (!have_cand_q || (s_data > max_val_q));
    assign atLast     = (idx_q == LAST_IDX);

    // Running peak including the current sample. The frame-end branch uses this
    // so the closing sample takes part in the comparison.
    assign candVal = takeSample ? s_data : max_val_q;
    assign candIdx = takeSample ? idx_q  : max_idx_q;

    if (ADDR_W <= IDX_W) begin : gAddrTrunc
        assign candAddr = candIdx[ADDR_W-1:0];
    end else begin : gAddrExt
        assign candAddr = {{(ADDR_W - IDX_W){1'b0}}, candIdx};
    end

    // Next-state logic. Cycles without s_valid leave everything frozen except
    // the two pulse outputs, which always fall back to zero. Any frame end,
    // good or bad, clears the search state so the very next sample is bin 0 of
    // a fresh frame with no stale peak carried over.
    always_comb begin
        idx_d        = idx_q;
        max_val_d    = max_val_q;
        max_idx_d    = max_idx_q;
        have_cand_d  = have_cand_q;
        data_d       = data_q;
        addr_d       = addr_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (s_valid) begin
            if (atLast && s_last) begin
                data_valid_d = 1'b1;
                data_d       = candVal;
                addr_d       = candAddr;
                idx_d        = '0;
                max_val_d    = '0;
                max_idx_d    = '0;
                have_cand_d  = 1'b0;
            end else if (atLast || s_last) begin
                // Short frame (early s_last) or missing s_last: drop the frame
                // and keep the previous result on data/addr.
                frame_err_d  = 1'b1;
                idx_d        = '0;
                max_val_d    = '0;
                max_idx_d    = '0;
                have_cand_d  = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
                if (takeSample) begin
                    max_val_d   = s_data;
                    max_idx_d   = idx_q;
                    have_cand_d = 1'b1;
                end
            end
        end
    end

    // State and output registers. Reset drops any partial frame and clears the
    // presented result as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            max_val_q    <= '0;
            max_idx_q    <= '0;
            have_cand_q  <= 1'b0;
            data_q       <= '0;
            addr_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            max_val_q    <= max_val_d;
            max_idx_q    <= max_idx_d;
            have_cand_q  <= have_cand_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_valid = data_valid_q;
    assign data       = data_q;
    assign addr       = addr_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// -----------------------------------------------------------------------------
// tb_spectrum_peak_finder
//
// Drives whole frames into spectrum_peak_finder and compares the reported peak
// with a reference computed by scanning the frame array directly. Covers reset
// values, ramp/tie/DC frames, short and missing-last frames, back-to-back
// frames with random s_valid gaps, and a reset in the middle of a frame.
// Honours PEAK_DC_SKIP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_spectrum_peak_finder;

    localparam int DATA_W     = 25;
    localparam int ADDR_W     = 11;
    localparam int FRAME_LEN  = 4096;
    localparam int SEARCH_LEN = 2048;
    localparam int DC_BINS    = 4;

    logic              clk;
    logic              rst;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              data_valid;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              frame_err;

    spectrum_peak_finder #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FRAME_LEN  (FRAME_LEN),
        .SEARCH_LEN (SEARCH_LEN),
        .DC_BINS    (DC_BINS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .data_valid (data_valid),
        .data       (data),
        .addr       (addr),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // Pulse counters sampled on the falling edge; a pulse wider than one cycle
    // shows up as an extra count.
    int dvCount  = 0;
    int errCount = 0;
    int expDv    = 0;
    int expErr   = 0;

    always @(negedge clk) begin
        if (data_valid) dvCount++;
        if (frame_err)  errCount++;
    end

    logic [DATA_W-1:0] frameBuf [FRAME_LEN];
    logic [DATA_W-1:0] heldData;
    logic [ADDR_W-1:0] heldAddr;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One clock of input; returns #1 after the edge that consumed it.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic l);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic sendIdle(input int n);
        repeat (n) applyStimulus(1'b0, '0, 1'b0);
    endtask

    // Sends frameBuf[0..nSamples-1]; s_last on sample lastAt (-1 for never).
    // Gap cycles carry garbage data/last to show they are ignored.
    task automatic sendFrame(input int nSamples, input int lastAt, input bit withGaps);
        for (int i = 0; i < nSamples; i++) begin
            if (withGaps && ($urandom_range(0, 7) == 0)) begin
                repeat ($urandom_range(1, 3))
                    applyStimulus(1'b0, DATA_W'($urandom), 1'($urandom));
            end
            applyStimulus(1'b1, frameBuf[i], (i == lastAt));
        end
    endtask

    // Reference: highest value over the candidate bins, lowest bin on ties.
    task automatic refPeak(output logic [DATA_W-1:0] val, output int bin);
        int lo;
        bit found;
`ifdef PEAK_DC_SKIP_EN
        lo = DC_BINS;
`else
        lo = 0;
`endif
        found = 0;
        val   = '0;
        bin   = 0;
        for (int i = lo; i < SEARCH_LEN; i++) begin
            if (!found || frameBuf[i] > val) begin
                val   = frameBuf[i];
                bin   = i;
                found = 1;
            end
        end
    endtask

    task automatic expectResult(input string name);
        logic [DATA_W-1:0] v;
        int b;
        refPeak(v, b);
        checkOutput({name, ".data_valid"}, data_valid, 1);
        checkOutput({name, ".frame_err"},  frame_err,  0);
        checkOutput({name, ".data"},       data,       v);
        checkOutput({name, ".addr"},       addr,       b);
        heldData = v;
        heldAddr = ADDR_W'(b);
        expDv++;
    endtask

    task automatic expectError(input string name);
        checkOutput({name, ".frame_err"},  frame_err,  1);
        checkOutput({name, ".data_valid"}, data_valid, 0);
        checkOutput({name, ".data_held"},  data,       heldData);
        checkOutput({name, ".addr_held"},  addr,       heldAddr);
        expErr++;
    endtask

    task automatic checkPulses(input string name);
        checkOutput({name, ".dv_pulses"},  dvCount,  expDv);
        checkOutput({name, ".err_pulses"}, errCount, expErr);
    endtask

    // Ramp in the searched half, random junk above it, huge mirrored bin 3000.
    task automatic buildRamp();
        for (int i = 0; i < FRAME_LEN; i++)
            frameBuf[i] = (i < SEARCH_LEN) ? DATA_W'(i) : DATA_W'($urandom);
        frameBuf[3000] = 25'h1FFFFFF;
    endtask

    task automatic buildPeak(input int peakBin, input logic [DATA_W-1:0] peakVal);
        for (int i = 0; i < FRAME_LEN; i++)
            frameBuf[i] = (i < SEARCH_LEN) ? DATA_W'($urandom_range(0, int'(peakVal) - 1))
                                           : DATA_W'($urandom);
        frameBuf[peakBin] = peakVal;
    endtask

    initial begin
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        heldData = '0;
        heldAddr = '0;
        rst      = 1'b1;
        sendIdle(3);
        checkOutput("reset.data_valid", data_valid, 0);
        checkOutput("reset.data",       data,       0);
        checkOutput("reset.addr",       addr,       0);
        checkOutput("reset.frame_err",  frame_err,  0);
        rst = 1'b0;
        sendIdle(2);

        // Ramp, tie and DC frames back to back with no gaps.
        buildRamp();
        sendFrame(FRAME_LEN, FRAME_LEN - 1, 1'b0);
        expectResult("ramp");
        checkOutput("ramp.peak_value", data, 2047);

        for (int i = 0; i < FRAME_LEN; i++) frameBuf[i] = 5;
        frameBuf[10] = 100;
        frameBuf[20] = 100;
        sendFrame(FRAME_LEN, FRAME_LEN - 1, 1'b0);
        expectResult("tie");
        checkOutput("tie.lowest_bin", addr, 10);

        for (int i = 0; i < FRAME_LEN; i++) frameBuf[i] = 1;
        frameBuf[0]   = 1000000;
        frameBuf[500] = 900;
        sendFrame(FRAME_LEN, FRAME_LEN - 1, 1'b0);
        expectResult("dc");
        sendIdle(2);
        checkPulses("first3");

        // Short frame, then a good ramp frame.
        buildRamp();
        sendFrame(101, 100, 1'b0);
        expectError("short");
        sendFrame(FRAME_LEN, FRAME_LEN - 1, 1'b0);
        expectResult("after_short");

        // Missing last: 4096 samples without s_last, then a ramp frame.
        sendFrame(FRAME_LEN, -1, 1'b0);
        expectError("nolast");
        sendFrame(FRAME_LEN, FRAME_LEN - 1, 1'b1);
        expectResult("after_nolast");
        sendIdle(2);
        checkPulses("errors");

        // Random low-range frames so ties happen, with random gaps.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FRAME_LEN; i++) frameBuf[i] = DATA_W'($urandom_range(0, 63));
            sendFrame(FRAME_LEN, FRAME_LEN - 1, 1'b1);
            expectResult("random");
        end

        // Known peaks back to back with gaps, then reset partway into a third frame.
        buildPeak(42, 777);
        sendFrame(FRAME_LEN, FRAME_LEN - 1, 1'b1);
        expectResult("peak777");
        checkOutput("peak777.addr_const", addr, 42);
        buildPeak(1234, 55);
        sendFrame(FRAME_LEN, FRAME_LEN - 1, 1'b1);
        expectResult("peak55");
        checkOutput("peak55.addr_const", addr, 1234);
        buildPeak(7, 999);
        sendFrame(2000, -1, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b1, 25'd12345, 1'b1);
        rst = 1'b0;
        checkOutput("midrst.data_valid", data_valid, 0);
        checkOutput("midrst.frame_err",  frame_err,  0);
        checkOutput("midrst.data",       data,       0);
        checkOutput("midrst.addr",       addr,       0);
        sendIdle(4);
        checkPulses("midrst");
        checkOutput("midrst.data_later", data, 0);

        // A full frame after reset proves the index restarted at 0.
        buildRamp();
        sendFrame(FRAME_LEN, FRAME_LEN - 1, 1'b0);
        expectResult("after_rst");
        sendIdle(3);
        checkPulses("final");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/spectrum_peak_finder.md
# spectrum_peak_finder

Scans one frame of FFT squared-magnitude samples, finds the largest bin in the lower (non-mirrored) half of the spectrum, and presents its magnitude and bin index as a one-cycle-valid result. Sits directly upstream of the UART result packer: its `data_valid`/`data`/`addr` outputs drive that stage's identically named inputs, which latch on `data_valid`. Input comes from the magnitude-squared stage after the FFT core.

## Interface
Parameters:
- `DATA_W`, 25: magnitude width.
- `ADDR_W`, 11: result index width.
- `FRAME_LEN`, 4096: samples per frame; power of two; index counter is log2(FRAME_LEN) bits.
- `SEARCH_LEN`, 2048: bins 0..SEARCH_LEN-1 are searched; must be ≤ 2^ADDR_W and > DC_BINS.
- `DC_BINS`, 4: low bins excluded when DC skip is compiled in.

Ports:
- Reset `rst`, synchronous, active-high; clock `clk`.
- `s_valid`  in  1  input sample strobe; no backpressure, one sample per asserted cycle.
- `s_data`  in  DATA_W  unsigned squared magnitude.
- `s_last`  in  1  marks final sample of frame; qualified by `s_valid`.
- `data_valid`  out  1  one-cycle pulse, result ready.
- `data`  out  DATA_W  peak magnitude; held until next result.
- `addr`  out  ADDR_W  peak bin index; held until next result.
- `frame_err`  out  1  one-cycle pulse, malformed frame discarded.

## Operation
- Internal `idx` counter (log2(FRAME_LEN) bits) counts accepted samples; 0 at reset and after every frame end or error.
- Candidate region: `idx < SEARCH_LEN` (and `idx ≥ DC_BINS` if DC skip enabled). Samples outside region are counted but never compared.
- Registers `max_val`, `max_idx`, `have_cand`. First candidate sample of a frame loads unconditionally and sets `have_cand`; later candidates load only if `s_data > max_val` (strict: lowest index wins ties).
- Frame end, normal: `s_valid && s_last && idx == FRAME_LEN-1` → result registered, including the comparison of that same sample (if a candidate).
- Error A: `s_valid && s_last && idx != FRAME_LEN-1` (short frame).
- Error B: `s_valid && !s_last && idx == FRAME_LEN-1` (missing last).
- On either error: `frame_err` pulses, no `data_valid`, `data`/`addr` keep previous result, `idx`/`have_cand` cleared; next sample is bin 0 of a new frame.
- `addr` = `max_idx[ADDR_W-1:0]`, zero-extended if narrower.
- `s_valid` low cycles: state frozen; gaps of any length allowed anywhere in a frame.

## Timing
- Reset values: `data_valid` 0, `data` 0, `addr` 0, `frame_err` 0; `idx` 0, `max_val` 0, `have_cand` 0.
- Latency: `data_valid`/`frame_err` assert on the cycle after the `s_valid` cycle that ended the frame; exactly one cycle wide.
- `data`/`addr` update on the same edge `data_valid` rises and are stable while it is high and thereafter.
- Back-to-back: a new frame's bin 0 may arrive the cycle immediately after `s_last`; it must be accepted as a fresh first candidate (no stale `max_val` carry-over) while the previous result is being presented.
- Reset mid-frame: partial frame dropped, no pulse on either output, previous result outputs cleared to 0.
- Throughput: one sample per cycle sustained, no stall.

## Configuration
- `PEAK_DC_SKIP_EN` defined: bins 0..DC_BINS-1 are excluded from the candidate region (suppresses ADC offset leakage).
- Not defined: candidate region is 0..SEARCH_LEN-1; `DC_BINS` unused.

## Test plan
- Ramp frame: `s_data = idx` for idx<2048, bin 3000 = 25'h1FFFFFF, full 4096 samples continuous → one `data_valid` one cycle after `s_last`, `data=2047`, `addr=2047` (mirrored bin ignored).
- Tie: all bins 5 except bins 10 and 20 = 100 → `data=100`, `addr=10`.
- DC: bin 0 = 1000000, bin 500 = 900, rest 1 → with `PEAK_DC_SKIP_EN` `addr=500 data=900`; without `addr=0 data=1000000`.
- Short frame: `s_last` at idx 100 → `frame_err` single pulse, no `data_valid`, outputs unchanged; following valid ramp frame → `addr=2047`.
- Missing last: 4096 samples with no `s_last`, then ramp frame → `frame_err` pulse on cycle after sample 4095, then correct result for next frame.
- Back-to-back frames with random `s_valid` gaps, peak 777 at bin 42 then 55 at bin 1234; plus `rst` asserted at idx 2000 of a third frame → results `(777,42)`, `(55,1234)`, no pulse after reset, outputs 0.
